// File: rtl/hs_accum_rx.sv
// Consumer side of the dav_/rfd four-phase handshake; accumulates N samples into sum/peak.
// Optional HS_ACCUM_DAV_SYNC_EN adds a two-flop synchronizer on dav_.
module hs_accum_rx #(
  parameter int unsigned W  = 3,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = 8,
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [W-1:0]  c,
  input  logic          dav_,
  output logic          rfd,
  output logic [SW-1:0] sum,
  output logic [W-1:0]  peak,
  output logic          done,
  output logic [CW-1:0] cnt
);

  typedef enum logic [1:0] {StWaitDav, StWaitRel, StAcc} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  smp_q, smp_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [W-1:0]  runmax_q, runmax_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [W-1:0]  peak_q, peak_d;
  logic          done_q, done_d;
  logic          rfd_q, rfd_d;
  logic          dav_use;

`ifdef HS_ACCUM_DAV_SYNC_EN
  logic dav_s1_q, dav_s2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dav_s1_q <= 1'b1;
      dav_s2_q <= 1'b1;
    end else begin
      dav_s1_q <= dav_;
      dav_s2_q <= dav_s1_q;
    end
  end

  assign dav_use = dav_s2_q;
`else
  assign dav_use = dav_;
`endif

  logic [SW-1:0] smp_ext;
  logic [SW-1:0] acc_next;
  logic [W-1:0]  max_next;

  assign smp_ext  = SW'(smp_q);
  assign acc_next = acc_q + smp_ext;
  assign max_next = (smp_q > runmax_q) ? smp_q : runmax_q;

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    acc_d    = acc_q;
    runmax_d = runmax_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    peak_d   = peak_q;
    done_d   = 1'b0;
    rfd_d    = rfd_q;
    unique case (state_q)
      StWaitDav: begin
        if (!dav_use) begin
          smp_d   = c;
          rfd_d   = 1'b0;
          state_d = StWaitRel;
        end
      end
      StWaitRel: begin
        if (dav_use) state_d = StAcc;
      end
      StAcc: begin
        rfd_d   = 1'b1;
        state_d = StWaitDav;
        if (cnt_q == CW'(N - 1)) begin
          sum_d    = acc_next;
          peak_d   = max_next;
          done_d   = 1'b1;
          acc_d    = '0;
          runmax_d = '0;
          cnt_d    = '0;
        end else begin
          acc_d    = acc_next;
          runmax_d = max_next;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: state_d = StWaitDav;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StWaitDav;
      smp_q    <= '0;
      acc_q    <= '0;
      runmax_q <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      peak_q   <= '0;
      done_q   <= 1'b0;
      rfd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      smp_q    <= smp_d;
      acc_q    <= acc_d;
      runmax_q <= runmax_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      peak_q   <= peak_d;
      done_q   <= done_d;
      rfd_q    <= rfd_d;
    end
  end

  assign rfd  = rfd_q;
  assign sum  = sum_q;
  assign peak = peak_q;
  assign done = done_q;
  assign cnt  = cnt_q;

endmodule

// File: tb/tb_hs_accum_rx.sv
// Directed bench for hs_accum_rx: a W=3/N=4/SW=8 instance plus an SW=4 instance for wrap.
module tb_hs_accum_rx;

`ifdef HS_ACCUM_DAV_SYNC_EN
  localparam int FallLat = 3;
  localparam int RiseLat = 4;
`else
  localparam int FallLat = 1;
  localparam int RiseLat = 2;
`endif

  logic       clock;
  logic       reset;
  logic [2:0] c;
  logic       dav_;
  logic       rfd, done;
  logic [7:0] sum;
  logic [2:0] peak;
  logic [1:0] cnt;
  logic       rfd4, done4;
  logic [3:0] sum4;
  logic [2:0] peak4;
  logic [1:0] cnt4;

  int vectors;
  int miscompares;
  int fall_lat, rise_lat;
  logic done_rise;

  hs_accum_rx #(.W(3), .N(4), .SW(8)) dut (
    .clock(clock), .reset(reset), .c(c), .dav_(dav_),
    .rfd(rfd), .sum(sum), .peak(peak), .done(done), .cnt(cnt)
  );

  hs_accum_rx #(.W(3), .N(4), .SW(4)) dut4 (
    .clock(clock), .reset(reset), .c(c), .dav_(dav_),
    .rfd(rfd4), .sum(sum4), .peak(peak4), .done(done4), .cnt(cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full handshake; checks both latencies and returns done as seen with rfd rising.
  task automatic send(input logic [2:0] v, output logic dr);
    int k;
    c    = v;
    dav_ = 1'b0;
    k = 0;
    do begin tick(); k++; end while (rfd && k < 20);
    check_eq("fall_lat", k, FallLat);
    repeat (2) tick();
    check_eq("rfd_hold", int'(rfd), 0);
    dav_ = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!rfd && k < 20);
    check_eq("rise_lat", k, RiseLat);
    dr = done;
  endtask

  initial begin
    int k;
    logic stayed_low;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    dav_  = 1'b1;
    c     = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_eq("rst_rfd", int'(rfd), 1);
    check_eq("rst_sum", int'(sum), 0);
    check_eq("rst_peak", int'(peak), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_cnt", int'(cnt), 0);

    // Single transfer
    send(3'd5, done_rise);
    check_eq("single_done", int'(done_rise), 0);
    check_eq("single_cnt", int'(cnt), 1);
    check_eq("single_sum", int'(sum), 0);

    // Reset while in WAIT_REL
    c = 3'd6;
    dav_ = 1'b0;
    k = 0;
    do begin tick(); k++; end while (rfd && k < 20);
    check_eq("midrel_rfd_low", int'(rfd), 0);
    reset = 1'b1;
    dav_  = 1'b1;
    tick();
    check_eq("midrel_rst_rfd", int'(rfd), 1);
    check_eq("midrel_rst_cnt", int'(cnt), 0);
    reset = 1'b0;
    tick();

    // Block 3,7,0,5
    send(3'd3, done_rise);
    check_eq("blk_done0", int'(done_rise), 0);
    send(3'd7, done_rise);
    check_eq("blk_done1", int'(done_rise), 0);
    send(3'd0, done_rise);
    check_eq("blk_done2", int'(done_rise), 0);
    send(3'd5, done_rise);
    check_eq("blk_done3", int'(done_rise), 1);
    check_eq("blk_sum", int'(sum), 15);
    check_eq("blk_peak", int'(peak), 7);
    check_eq("blk_cnt", int'(cnt), 0);
    tick();
    check_eq("blk_done_width", int'(done), 0);
    check_eq("blk_sum_hold", int'(sum), 15);

    // Partial block discarded by reset
    send(3'd3, done_rise);
    send(3'd3, done_rise);
    check_eq("part_cnt", int'(cnt), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("part_rst_sum", int'(sum), 0);
    tick();
    for (int i = 0; i < 4; i++) send(3'd1, done_rise);
    check_eq("ones_done", int'(done_rise), 1);
    check_eq("ones_sum", int'(sum), 4);
    check_eq("ones_peak", int'(peak), 1);

    // dav_ held low 20 cycles; c changes after capture
    c = 3'd2;
    dav_ = 1'b0;
    k = 0;
    do begin tick(); k++; end while (rfd && k < 20);
    check_eq("long_fall_lat", k, FallLat);
    stayed_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      c = 3'(7 - (i % 4));
      tick();
      if (rfd) stayed_low = 1'b0;
    end
    check_eq("long_rfd_low", int'(stayed_low), 1);
    dav_ = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!rfd && k < 20);
    check_eq("long_rise_lat", k, RiseLat);
    check_eq("long_cnt", int'(cnt), 1);
    for (int i = 0; i < 3; i++) send(3'd1, done_rise);
    check_eq("long_sum", int'(sum), 5);
    check_eq("long_peak", int'(peak), 2);

    // Wrap: 7*4 = 28 -> 12 on the 4-bit sum
    for (int i = 0; i < 4; i++) send(3'd7, done_rise);
    check_eq("wrap_done4", int'(done4), 1);
    check_eq("wrap_sum4", int'(sum4), 12);
    check_eq("wrap_peak4", int'(peak4), 7);
    check_eq("wrap_sum8", int'(sum), 28);
    check_eq("wrap_cnt4", int'(cnt4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
